// File: rtl/sfp_row_norm.sv
// Row-wise normaliser: sums |lane| per row into a local and an export queue, then
// divides a later row by the combined two-core sum with an iterative restoring divider.
module sfp_row_norm #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int depth   = 16,
  parameter int shift   = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      acc,
  input  logic                      div,
  input  logic [col*bw_psum-1:0]    sfp_in,
  input  logic [bw_psum+3:0]        sum_in,
  input  logic                      sum_in_valid,
  input  logic                      sum_out_rd,
  output logic [bw_psum+3:0]        sum_out,
  output logic                      sum_out_valid,
  output logic                      div_ready,
  output logic [col*bw_psum-1:0]    sfp_out,
  output logic                      out_valid,
  output logic                      div_by_zero,
  output logic                      overflow
);
  localparam int SW = bw_psum + 4;
  localparam int DW = bw_psum + 5 - shift;
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(bw_psum + 1);

  // Handshake: a row is taken on a rising edge where div && div_ready; the caller
  // holds div and sfp_in until then. acc owns the sfp_in bus whenever it is high.

  typedef enum logic {IDLE, DIV} state_t;
  state_t state, state_nxt;

  function automatic logic [bw_psum-1:0] mag_of(input logic [bw_psum-1:0] v);
    return v[bw_psum-1] ? (~v + bw_psum'(1)) : v;
  endfunction

  logic [SW-1:0] row_sum;
  always_comb begin
    row_sum = '0;
    for (int i = 0; i < col; i++)
      row_sum = row_sum + SW'(mag_of(sfp_in[bw_psum*i +: bw_psum]));
  end

  // Local queue feeds the divider, export queue feeds the partner core.
  logic [SW-1:0] iq_mem [depth];
  logic [SW-1:0] eq_mem [depth];
  logic [AW:0]   iq_wp, iq_rp, eq_wp, eq_rp;
  logic          iq_empty, iq_full, eq_empty, eq_full;
  logic          iq_pop, eq_pop, iq_push, eq_push, accept;
  logic [SW-1:0] iq_head;
  logic [DW-1:0] d_calc;

  assign iq_empty = (iq_wp == iq_rp);
  assign eq_empty = (eq_wp == eq_rp);
  assign iq_full  = (iq_wp[AW] != iq_rp[AW]) && (iq_wp[AW-1:0] == iq_rp[AW-1:0]);
  assign eq_full  = (eq_wp[AW] != eq_rp[AW]) && (eq_wp[AW-1:0] == eq_rp[AW-1:0]);
  assign iq_head  = iq_mem[iq_rp[AW-1:0]];

  assign div_ready = (state == IDLE) && !iq_empty && sum_in_valid && !acc;
  assign accept    = div && div_ready;
  assign iq_pop    = accept;
  assign eq_pop    = sum_out_rd && !eq_empty;
  assign iq_push   = acc && (!iq_full || iq_pop);
  assign eq_push   = acc && (!eq_full || eq_pop);
  assign d_calc    = DW'(iq_head >> shift) + DW'(sum_in >> shift);

  assign sum_out       = eq_empty ? '0 : eq_mem[eq_rp[AW-1:0]];
  assign sum_out_valid = !eq_empty;

  always_ff @(posedge clk) begin
    if (iq_push) iq_mem[iq_wp[AW-1:0]] <= row_sum;
    if (eq_push) eq_mem[eq_wp[AW-1:0]] <= row_sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iq_wp    <= '0;
      iq_rp    <= '0;
      eq_wp    <= '0;
      eq_rp    <= '0;
      overflow <= 1'b0;
    end else begin
      if (iq_push) iq_wp <= iq_wp + (AW+1)'(1);
      if (iq_pop)  iq_rp <= iq_rp + (AW+1)'(1);
      if (eq_push) eq_wp <= eq_wp + (AW+1)'(1);
      if (eq_pop)  eq_rp <= eq_rp + (AW+1)'(1);
      if (acc && ((iq_full && !iq_pop) || (eq_full && !eq_pop)))
        overflow <= 1'b1;
    end
  end

  logic [CW-1:0]      cnt;
  logic [DW-1:0]      divisor;
  logic               dz;
  logic               neg     [col];
  logic [DW-1:0]      rem     [col];
  logic [bw_psum-1:0] quo     [col];
  logic [DW-1:0]      rem_nxt [col];
  logic [bw_psum-1:0] quo_nxt [col];
  logic [col*bw_psum-1:0] res_pk;
  logic               last_iter;

  assign last_iter = (state == DIV) && (cnt == CW'(bw_psum - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = DIV;
      DIV:  if (last_iter) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // One restoring step per cycle: dividend bits stream out of quo's MSB while
  // quotient bits shift into its LSB.
  always_comb begin : div_step
    logic [DW:0]        trial;
    logic [DW:0]        diff;
    logic [bw_psum-1:0] q;
    res_pk = '0;
    for (int i = 0; i < col; i++) begin
      trial = {rem[i], quo[i][bw_psum-1]};
      diff  = trial - {1'b0, divisor};
      if (trial >= {1'b0, divisor}) begin
        rem_nxt[i] = diff[DW-1:0];
        q          = {quo[i][bw_psum-2:0], 1'b1};
      end else begin
        rem_nxt[i] = trial[DW-1:0];
        q          = {quo[i][bw_psum-2:0], 1'b0};
      end
      quo_nxt[i] = q;
      res_pk[bw_psum*i +: bw_psum] = neg[i] ? (~q + bw_psum'(1)) : q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      divisor     <= '0;
      dz          <= 1'b0;
      sfp_out     <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      for (int i = 0; i < col; i++) begin
        neg[i] <= 1'b0;
        rem[i] <= '0;
        quo[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        cnt     <= '0;
        divisor <= d_calc;
        dz      <= (d_calc == '0);
        for (int i = 0; i < col; i++) begin
          neg[i] <= sfp_in[bw_psum*i + bw_psum - 1];
          rem[i] <= '0;
          quo[i] <= mag_of(sfp_in[bw_psum*i +: bw_psum]);
        end
      end else if (state == DIV) begin
        cnt <= cnt + CW'(1);
        for (int i = 0; i < col; i++) begin
          rem[i] <= rem_nxt[i];
          quo[i] <= quo_nxt[i];
        end
        if (last_iter) begin
          sfp_out     <= dz ? '0 : res_pk;
          div_by_zero <= dz;
          out_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sfp_row_norm.sv
// Directed bench for sfp_row_norm with default parameters (8 lanes x 20 bits).
module tb_sfp_row_norm;
  localparam int COL = 8;
  localparam int BWP = 20;
  localparam int SW  = 24;

  logic                 clk = 1'b0;
  logic                 reset, acc, div, sum_in_valid, sum_out_rd;
  logic [COL*BWP-1:0]   sfp_in;
  logic [SW-1:0]        sum_in;
  logic [SW-1:0]        sum_out;
  logic                 sum_out_valid, div_ready, out_valid, div_by_zero, overflow;
  logic [COL*BWP-1:0]   sfp_out;

  int n_checks = 0;
  int n_fail   = 0;
  int lv [COL];
  int ev [COL];

  sfp_row_norm dut (
    .clk(clk), .reset(reset), .acc(acc), .div(div), .sfp_in(sfp_in),
    .sum_in(sum_in), .sum_in_valid(sum_in_valid), .sum_out_rd(sum_out_rd),
    .sum_out(sum_out), .sum_out_valid(sum_out_valid), .div_ready(div_ready),
    .sfp_out(sfp_out), .out_valid(out_valid), .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put_lanes;
    for (int i = 0; i < COL; i++) sfp_in[i*BWP +: BWP] = BWP'(lv[i]);
  endtask

  task automatic do_reset;
    reset = 1'b1; acc = 1'b0; div = 1'b0; sum_in = '0; sum_in_valid = 1'b0;
    sum_out_rd = 1'b0; sfp_in = '0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    sum_in_valid = 1'b1;
    #1;
    n_checks++; if (sum_out !== '0) begin n_fail++; $display("FAIL rst_sum_out: got %0d expected 0", sum_out); end
    n_checks++; if (sum_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_sum_out_valid: got %b expected 0", sum_out_valid); end
    n_checks++; if (div_ready !== 1'b0) begin n_fail++; $display("FAIL rst_div_ready: got %b expected 0", div_ready); end
    n_checks++; if (sfp_out !== '0) begin n_fail++; $display("FAIL rst_sfp_out: got %h expected 0", sfp_out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rst_div_by_zero: got %b expected 0", div_by_zero); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_basic;
    int lat;
    do_reset;
    lv = '{1000, -1000, 500, -500, 0, 0, 0, 0};
    put_lanes;
    acc = 1'b1;
    tick;
    acc = 1'b0;
    n_checks++; if (sum_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_sum_valid: got %b expected 1", sum_out_valid); end
    n_checks++; if (sum_out !== SW'(3000)) begin n_fail++; $display("FAIL basic_sum: got %0d expected 3000", sum_out); end
    sum_in = SW'(3000); sum_in_valid = 1'b1; div = 1'b1;
    #1;
    n_checks++; if (div_ready !== 1'b1) begin n_fail++; $display("FAIL basic_div_ready: got %b expected 1", div_ready); end
    tick;
    div = 1'b0;
    wait_result(lat);
    n_checks++; if (lat != 20) begin n_fail++; $display("FAIL basic_latency: got %0d expected 20", lat); end
    ev = '{21, -21, 10, -10, 0, 0, 0, 0};
    for (int i = 0; i < COL; i++) begin
      n_checks++;
      if (sfp_out[i*BWP +: BWP] !== BWP'(ev[i])) begin
        n_fail++; $display("FAIL basic_lane%0d: got %0d expected %0d", i, $signed(sfp_out[i*BWP +: BWP]), ev[i]);
      end
    end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b expected 0", div_by_zero); end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b expected 0", out_valid); end
  endtask

  task automatic test_neg_min;
    int lat;
    do_reset;
    lv = '{-524288, 0, 0, 0, 0, 0, 0, 0};
    put_lanes;
    acc = 1'b1;
    tick;
    acc = 1'b0;
    n_checks++; if (sum_out !== SW'(524288)) begin n_fail++; $display("FAIL negmin_sum: got %0d expected 524288", sum_out); end
    sum_in = SW'(128); sum_in_valid = 1'b1; div = 1'b1;
    tick;
    div = 1'b0;
    wait_result(lat);
    n_checks++; if (lat != 20) begin n_fail++; $display("FAIL negmin_latency: got %0d expected 20", lat); end
    n_checks++;
    if (sfp_out[BWP-1:0] !== BWP'(-127)) begin
      n_fail++; $display("FAIL negmin_lane0: got %0d expected -127", $signed(sfp_out[BWP-1:0]));
    end
    n_checks++; if (sfp_out[COL*BWP-1:BWP] !== '0) begin n_fail++; $display("FAIL negmin_rest: got %h expected 0", sfp_out[COL*BWP-1:BWP]); end
  endtask

  task automatic test_div_zero;
    int lat;
    do_reset;
    lv = '{0, 0, 0, 0, 0, 0, 0, 0};
    put_lanes;
    acc = 1'b1;
    tick;
    acc = 1'b0;
    sum_in = '0; sum_in_valid = 1'b1; div = 1'b1;
    tick;
    div = 1'b0;
    wait_result(lat);
    n_checks++; if (lat != 20) begin n_fail++; $display("FAIL dz_latency: got %0d expected 20", lat); end
    n_checks++; if (sfp_out !== '0) begin n_fail++; $display("FAIL dz_sfp_out: got %h expected 0", sfp_out); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    tick; tick; tick;
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_hold: got %b expected 1", div_by_zero); end
  endtask

  task automatic test_overflow;
    do_reset;
    lv = '{0, 0, 0, 0, 0, 0, 0, 0};
    acc = 1'b1;
    for (int j = 0; j < 17; j++) begin
      lv[0] = 100 + j;
      put_lanes;
      tick;
      if (j == 15) begin
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      end
    end
    acc = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    for (int j = 0; j < 16; j++) begin
      n_checks++; if (sum_out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid%0d: got %b expected 1", j, sum_out_valid); end
      n_checks++; if (sum_out !== SW'(100 + j)) begin n_fail++; $display("FAIL ovf_order%0d: got %0d expected %0d", j, sum_out, 100 + j); end
      sum_out_rd = 1'b1;
      tick;
    end
    n_checks++; if (sum_out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", sum_out_valid); end
    tick;
    sum_out_rd = 1'b0;
    n_checks++; if (sum_out !== '0) begin n_fail++; $display("FAIL ovf_extra_rd: got %0d expected 0", sum_out); end
    n_checks++; if (sum_out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_extra_valid: got %b expected 0", sum_out_valid); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_acc_priority;
    int lat;
    do_reset;
    lv = '{1000, -1000, 500, -500, 0, 0, 0, 0};
    put_lanes;
    acc = 1'b1;
    tick;
    lv = '{2000, 0, 0, 0, 0, 0, 0, 0};
    put_lanes;
    sum_in = SW'(3000); sum_in_valid = 1'b1; div = 1'b1;
    #1;
    n_checks++; if (div_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready_acc: got %b expected 0", div_ready); end
    tick;
    acc = 1'b0;
    #1;
    n_checks++; if (div_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready: got %b expected 1", div_ready); end
    n_checks++; if (sum_out !== SW'(3000)) begin n_fail++; $display("FAIL prio_head: got %0d expected 3000", sum_out); end
    tick;
    div = 1'b0;
    wait_result(lat);
    n_checks++; if (lat != 20) begin n_fail++; $display("FAIL prio_latency: got %0d expected 20", lat); end
    n_checks++;
    if (sfp_out[BWP-1:0] !== BWP'(43)) begin
      n_fail++; $display("FAIL prio_lane0: got %0d expected 43", $signed(sfp_out[BWP-1:0]));
    end
    n_checks++; if (div_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready_again: got %b expected 1", div_ready); end
  endtask

  task automatic test_reset_mid_div;
    bit seen_valid, seen_ready;
    do_reset;
    lv = '{1000, -1000, 500, -500, 0, 0, 0, 0};
    put_lanes;
    acc = 1'b1;
    tick;
    acc = 1'b0;
    sum_in = SW'(3000); sum_in_valid = 1'b1; div = 1'b1;
    tick;
    div = 1'b0;
    for (int n = 0; n < 5; n++) tick;
    reset = 1'b1;
    #1;
    n_checks++; if (sum_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_sum_valid: got %b expected 0", sum_out_valid); end
    n_checks++; if (div_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b expected 0", div_ready); end
    n_checks++; if (sfp_out !== '0) begin n_fail++; $display("FAIL rmid_sfp_out: got %h expected 0", sfp_out); end
    tick;
    reset = 1'b0;
    seen_valid = 1'b0;
    seen_ready = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick;
      if (out_valid) seen_valid = 1'b1;
      if (div_ready) seen_ready = 1'b1;
    end
    n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_out_valid: got %b expected 0", seen_valid); end
    n_checks++; if (seen_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_low: got %b expected 0", seen_ready); end
    acc = 1'b1;
    tick;
    acc = 1'b0;
    #1;
    n_checks++; if (div_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_after_acc: got %b expected 1", div_ready); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_neg_min;
    test_div_zero;
    test_overflow;
    test_acc_priority;
    test_reset_mid_div;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
